rs_alu_scheduler: RTL and testbench

//  ALU reservation station and issue scheduler for the Tomasulo core. Buffers decoded ALU/branch/jump ops, waits for operands

---
 rtl/rs_alu_scheduler_pkg.sv | 61 ++++++
 rtl/rs_alu_scheduler_prio_enc.sv | 23 ++
 rtl/rs_alu_scheduler.sv | 131 +++++++++++++
 tb/tb_rs_alu_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types and constants for the ALU reservation station: sizes, op codes,
// the entry record and the bypass-bus snoop used at both allocation and wakeup.
package rs_alu_scheduler_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = $clog2(RS_SIZE);
  localparam int ROB_W    = 4;
  localparam int TYPE_W   = 6;
  localparam int DATA_W   = 32;

  typedef enum logic [TYPE_W-1:0] {
    INS_NOP = 6'd0,
    INS_LUI, INS_AUIPC, INS_JAL, INS_JALR,
    INS_BEQ, INS_BNE, INS_BLT, INS_BGE, INS_BLTU, INS_BGEU,
    INS_LB, INS_LH, INS_LW, INS_LBU, INS_LHU, INS_SB, INS_SH, INS_SW,
    INS_ADDI, INS_SLTI, INS_SLTIU, INS_XORI, INS_ORI, INS_ANDI,
    INS_SLLI, INS_SRLI, INS_SRAI,
    INS_ADD, INS_SUB, INS_SLL, INS_SLT, INS_SLTU, INS_XOR,
    INS_SRL, INS_SRA, INS_OR, INS_AND
  } ins_type_e;

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  tag;
  } operand_t;

  typedef struct packed {
    logic [TYPE_W-1:0] ins_type;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  reorder;
    operand_t          rs1;
    operand_t          rs2;
  } rs_entry_t;

  // A busy operand picks up a matching broadcast; the ALU bus has priority.
  function automatic operand_t snoop(
    input operand_t          op,
    input logic              alu_en,
    input logic [ROB_W-1:0]  alu_tag,
    input logic [DATA_W-1:0] alu_val,
    input logic              lsu_en,
    input logic [ROB_W-1:0]  lsu_tag,
    input logic [DATA_W-1:0] lsu_val
  );
    operand_t res;
    res = op;
    if (op.busy) begin
      if (alu_en && alu_tag == op.tag) begin
        res.busy = 1'b0;
        res.val  = alu_val;
      end else if (lsu_en && lsu_tag == op.tag) begin
        res.busy = 1'b0;
        res.val  = lsu_val;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_alu_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder; used to pick the free slot and the issue slot.
module rs_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: allocates decoded ops, snoops ALU/LSU result buses,
// and issues the lowest-index ready entry as a registered packet each cycle.
module rs_alu_scheduler
  import rs_alu_scheduler_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_flush,
  input  logic              dec2rs_enable,
  input  logic [TYPE_W-1:0] dec2rs_ins_type,
  input  logic [DATA_W-1:0] dec2rs_pc,
  input  logic [DATA_W-1:0] dec2rs_imm,
  input  logic [ROB_W-1:0]  dec2rs_reorder,
  input  logic              dec2rs_rs1_busy,
  input  logic [DATA_W-1:0] dec2rs_rs1_val,
  input  logic [ROB_W-1:0]  dec2rs_rs1_tag,
  input  logic              dec2rs_rs2_busy,
  input  logic [DATA_W-1:0] dec2rs_rs2_val,
  input  logic [ROB_W-1:0]  dec2rs_rs2_tag,
  output logic              rs2dec_full,
  output logic              rs2alu_enable,
  output logic [TYPE_W-1:0] rs2alu_ins_type,
  output logic [DATA_W-1:0] rs2alu_pc,
  output logic [DATA_W-1:0] rs2alu_imm,
  output logic [DATA_W-1:0] rs2alu_rs1,
  output logic [DATA_W-1:0] rs2alu_rs2,
  output logic [ROB_W-1:0]  rs2alu_reorder,
  input  logic              alu2rs_bypass_enable,
  input  logic [ROB_W-1:0]  alu2rs_bypass_reorder,
  input  logic [DATA_W-1:0] alu2rs_bypass_value,
  input  logic              lsu2rs_bypass_enable,
  input  logic [ROB_W-1:0]  lsu2rs_bypass_reorder,
  input  logic [DATA_W-1:0] lsu2rs_bypass_value
);

  localparam logic [RS_SIZE-1:0] ONE_HOT0 = {{(RS_SIZE-1){1'b0}}, 1'b1};

  logic [RS_SIZE-1:0]  valid_q;
  rs_entry_t           entry_q [RS_SIZE];

  logic [RS_SIZE-1:0]  free_vec, ready_vec, issue_mask, alloc_mask;
  logic [RS_IDX_W-1:0] alloc_idx, issue_idx;
  logic                alloc_found, issue_found;
  rs_entry_t           new_entry;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !valid_q[i];
      ready_vec[i] = valid_q[i] && !entry_q[i].rs1.busy && !entry_q[i].rs2.busy;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
    .req   (free_vec),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_enc (
    .req   (ready_vec),
    .idx   (issue_idx),
    .found (issue_found)
  );

  assign rs2dec_full = &valid_q;
  assign issue_mask  = issue_found ? (ONE_HOT0 << issue_idx) : '0;
  assign alloc_mask  = (dec2rs_enable && alloc_found) ? (ONE_HOT0 << alloc_idx) : '0;

  // Operands arriving on a bus in the allocation cycle are captured immediately.
  always_comb begin
    new_entry.ins_type = dec2rs_ins_type;
    new_entry.pc       = dec2rs_pc;
    new_entry.imm      = dec2rs_imm;
    new_entry.reorder  = dec2rs_reorder;
    new_entry.rs1 = snoop({dec2rs_rs1_busy, dec2rs_rs1_val, dec2rs_rs1_tag},
                          alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                          lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
    new_entry.rs2 = snoop({dec2rs_rs2_busy, dec2rs_rs2_val, dec2rs_rs2_tag},
                          alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                          lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
  end

  // Control state and issue register; flush behaves exactly like reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_in || rob_flush) begin
      valid_q         <= '0;
      rs2alu_enable   <= 1'b0;
      rs2alu_ins_type <= '0;
      rs2alu_pc       <= '0;
      rs2alu_imm      <= '0;
      rs2alu_rs1      <= '0;
      rs2alu_rs2      <= '0;
      rs2alu_reorder  <= '0;
    end else if (!rdy_in) begin
      rs2alu_enable <= 1'b0;
    end else begin
      rs2alu_enable <= issue_found;
      if (issue_found) begin
        rs2alu_ins_type <= entry_q[issue_idx].ins_type;
        rs2alu_pc       <= entry_q[issue_idx].pc;
        rs2alu_imm      <= entry_q[issue_idx].imm;
        rs2alu_rs1      <= entry_q[issue_idx].rs1.val;
        rs2alu_rs2      <= entry_q[issue_idx].rs2.val;
        rs2alu_reorder  <= entry_q[issue_idx].reorder;
      end
      valid_q <= (valid_q & ~issue_mask) | alloc_mask;
    end
  end

  // NOTE: payload array is not reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entry_q[i].rs1 <= snoop(entry_q[i].rs1,
                                alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                                lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
        entry_q[i].rs2 <= snoop(entry_q[i].rs2,
                                alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                                lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
      end
      if (dec2rs_enable && alloc_found) begin
        entry_q[alloc_idx] <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Bench for rs_alu_scheduler: table-driven allocations plus hand sequences,
// with a scoreboard queue checked whenever an issue packet appears.
module tb_rs_alu_scheduler;
  import rs_alu_scheduler_pkg::*;

  logic              clk_in, rst_in, rdy_in, rob_flush;
  logic              dec2rs_enable;
  logic [TYPE_W-1:0] dec2rs_ins_type;
  logic [31:0]       dec2rs_pc, dec2rs_imm, dec2rs_rs1_val, dec2rs_rs2_val;
  logic [ROB_W-1:0]  dec2rs_reorder, dec2rs_rs1_tag, dec2rs_rs2_tag;
  logic              dec2rs_rs1_busy, dec2rs_rs2_busy;
  logic              rs2dec_full, rs2alu_enable;
  logic [TYPE_W-1:0] rs2alu_ins_type;
  logic [31:0]       rs2alu_pc, rs2alu_imm, rs2alu_rs1, rs2alu_rs2;
  logic [ROB_W-1:0]  rs2alu_reorder;
  logic              alu2rs_bypass_enable, lsu2rs_bypass_enable;
  logic [ROB_W-1:0]  alu2rs_bypass_reorder, lsu2rs_bypass_reorder;
  logic [31:0]       alu2rs_bypass_value, lsu2rs_bypass_value;

  rs_alu_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_flush(rob_flush),
    .dec2rs_enable(dec2rs_enable), .dec2rs_ins_type(dec2rs_ins_type),
    .dec2rs_pc(dec2rs_pc), .dec2rs_imm(dec2rs_imm), .dec2rs_reorder(dec2rs_reorder),
    .dec2rs_rs1_busy(dec2rs_rs1_busy), .dec2rs_rs1_val(dec2rs_rs1_val), .dec2rs_rs1_tag(dec2rs_rs1_tag),
    .dec2rs_rs2_busy(dec2rs_rs2_busy), .dec2rs_rs2_val(dec2rs_rs2_val), .dec2rs_rs2_tag(dec2rs_rs2_tag),
    .rs2dec_full(rs2dec_full), .rs2alu_enable(rs2alu_enable),
    .rs2alu_ins_type(rs2alu_ins_type), .rs2alu_pc(rs2alu_pc), .rs2alu_imm(rs2alu_imm),
    .rs2alu_rs1(rs2alu_rs1), .rs2alu_rs2(rs2alu_rs2), .rs2alu_reorder(rs2alu_reorder),
    .alu2rs_bypass_enable(alu2rs_bypass_enable), .alu2rs_bypass_reorder(alu2rs_bypass_reorder),
    .alu2rs_bypass_value(alu2rs_bypass_value),
    .lsu2rs_bypass_enable(lsu2rs_bypass_enable), .lsu2rs_bypass_reorder(lsu2rs_bypass_reorder),
    .lsu2rs_bypass_value(lsu2rs_bypass_value)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [TYPE_W-1:0] ins_type;
    logic [31:0]       pc, imm, rs1, rs2;
    logic [ROB_W-1:0]  reorder;
  } pkt_t;

  typedef struct {
    logic [TYPE_W-1:0] ins_type;
    logic [31:0]       pc, imm;
    logic              b1;
    logic [31:0]       v1;
    logic [3:0]        t1;
    logic              b2;
    logic [31:0]       v2;
    logic [3:0]        t2;
    logic [3:0]        rob;
    logic              alu_en;
    logic [3:0]        alu_tag;
    logic [31:0]       alu_val;
    logic              lsu_en;
    logic [3:0]        lsu_tag;
    logic [31:0]       lsu_val;
    logic [31:0]       exp_rs1, exp_rs2;
  } vec_t;

  pkt_t exp_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    dec2rs_enable = 1'b0; dec2rs_ins_type = '0; dec2rs_pc = '0; dec2rs_imm = '0;
    dec2rs_reorder = '0; dec2rs_rs1_busy = 1'b0; dec2rs_rs1_val = '0; dec2rs_rs1_tag = '0;
    dec2rs_rs2_busy = 1'b0; dec2rs_rs2_val = '0; dec2rs_rs2_tag = '0;
    alu2rs_bypass_enable = 1'b0; alu2rs_bypass_reorder = '0; alu2rs_bypass_value = '0;
    lsu2rs_bypass_enable = 1'b0; lsu2rs_bypass_reorder = '0; lsu2rs_bypass_value = '0;
  endtask

  task automatic set_alloc(input logic [TYPE_W-1:0] t, input logic [31:0] pc, input logic [31:0] imm,
                           input logic b1, input logic [31:0] v1, input logic [3:0] t1,
                           input logic b2, input logic [31:0] v2, input logic [3:0] t2,
                           input logic [3:0] rob);
    dec2rs_enable = 1'b1; dec2rs_ins_type = t; dec2rs_pc = pc; dec2rs_imm = imm;
    dec2rs_rs1_busy = b1; dec2rs_rs1_val = v1; dec2rs_rs1_tag = t1;
    dec2rs_rs2_busy = b2; dec2rs_rs2_val = v2; dec2rs_rs2_tag = t2;
    dec2rs_reorder = rob;
  endtask

  task automatic push(input logic [TYPE_W-1:0] t, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] rob);
    pkt_t p;
    p.ins_type = t; p.pc = pc; p.imm = imm; p.rs1 = r1; p.rs2 = r2; p.reorder = rob;
    exp_q.push_back(p);
  endtask

  function automatic vec_t mk(input logic [TYPE_W-1:0] t, input logic [31:0] pc, input logic [31:0] imm,
                              input logic b1, input logic [31:0] v1, input logic [3:0] t1,
                              input logic b2, input logic [31:0] v2, input logic [3:0] t2,
                              input logic [3:0] rob,
                              input logic ae, input logic [3:0] at, input logic [31:0] av,
                              input logic le, input logic [3:0] lt, input logic [31:0] lv,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.ins_type = t; v.pc = pc; v.imm = imm; v.b1 = b1; v.v1 = v1; v.t1 = t1;
    v.b2 = b2; v.v2 = v2; v.t2 = t2; v.rob = rob;
    v.alu_en = ae; v.alu_tag = at; v.alu_val = av;
    v.lsu_en = le; v.lsu_tag = lt; v.lsu_val = lv;
    v.exp_rs1 = e1; v.exp_rs2 = e2;
    return v;
  endfunction

  // Scoreboard: every issue must match the oldest expected packet.
  always @(negedge clk_in) begin
    if (rs2alu_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc=0x%0h rob=%0d, expected no issue", rs2alu_pc, rs2alu_reorder);
      end else begin
        pkt_t p;
        p = exp_q.pop_front();
        check("issue_type",    32'(rs2alu_ins_type), 32'(p.ins_type));
        check("issue_pc",      rs2alu_pc,            p.pc);
        check("issue_imm",     rs2alu_imm,           p.imm);
        check("issue_rs1",     rs2alu_rs1,           p.rs1);
        check("issue_rs2",     rs2alu_rs2,           p.rs2);
        check("issue_reorder", 32'(rs2alu_reorder),  32'(p.reorder));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Ready ALU op, alloc-time LSU capture, both buses on one tag, mixed capture, branch, LUI.
    vecs[0] = mk(INS_ADDI, 32'h0000_0400, 32'd3,         0, 32'd5, 0, 0, 32'd0, 0, 4'd2,
                 0, 0, 0, 0, 0, 0, 32'd5, 32'd0);
    vecs[1] = mk(INS_ADD,  32'h0000_0404, 32'd0,         1, 32'd0, 3, 0, 32'd7, 0, 4'd4,
                 0, 0, 0, 1, 4'd3, 32'hAB, 32'hAB, 32'd7);
    vecs[2] = mk(INS_ADD,  32'h0000_0408, 32'd0,         1, 32'd0, 4, 0, 32'd9, 0, 4'd5,
                 1, 4'd4, 32'h11, 1, 4'd4, 32'h22, 32'h11, 32'd9);
    vecs[3] = mk(INS_SUB,  32'h0000_040C, 32'd0,         1, 32'd0, 6, 1, 32'd0, 8, 4'd6,
                 1, 4'd6, 32'h100, 1, 4'd8, 32'h200, 32'h100, 32'h200);
    vecs[4] = mk(INS_BEQ,  32'h0000_0410, 32'hFFFF_FFF8, 0, 32'd1, 0, 0, 32'd1, 0, 4'd7,
                 0, 0, 0, 0, 0, 0, 32'd1, 32'd1);
    vecs[5] = mk(INS_LUI,  32'h0000_0414, 32'h1234_5000, 0, 32'd0, 0, 0, 32'd0, 0, 4'd8,
                 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

    // Reset held two edges with an allocation request that must be dropped.
    rdy_in = 1'b1; rob_flush = 1'b0; rst_in = 1'b1;
    clear_inputs();
    set_alloc(INS_ADDI, 32'h0000_0BAD, 32'd1, 0, 32'd1, 0, 0, 32'd1, 0, 4'd1);
    cycle();
    cycle();
    rst_in = 1'b0;
    clear_inputs();
    check("reset_enable",   32'(rs2alu_enable),  32'd0);
    check("reset_full",     32'(rs2dec_full),    32'd0);
    check("reset_pc",       rs2alu_pc,           32'd0);
    check("reset_rs1",      rs2alu_rs1,          32'd0);
    check("reset_type",     32'(rs2alu_ins_type), 32'd0);
    check("reset_reorder",  32'(rs2alu_reorder), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("post_reset_idle", 32'(rs2alu_enable), 32'd0);
    end

    // Ready allocation: packet registered on the edge after the allocating edge.
    set_alloc(INS_ADDI, 32'h0000_0100, 32'd3, 0, 32'd5, 0, 0, 32'd0, 0, 4'd2);
    push(INS_ADDI, 32'h0000_0100, 32'd3, 32'd5, 32'd0, 4'd2);
    cycle();
    clear_inputs();
    check("lat_alloc_edge", 32'(rs2alu_enable), 32'd0);
    cycle();
    check("lat_issue_edge", 32'(rs2alu_enable), 32'd1);
    check("lat_issue_rs1",  rs2alu_rs1,         32'd5);
    cycle();

    // Table-driven allocations, one per cycle.
    for (int i = 0; i < 6; i++) begin
      set_alloc(vecs[i].ins_type, vecs[i].pc, vecs[i].imm, vecs[i].b1, vecs[i].v1, vecs[i].t1,
                vecs[i].b2, vecs[i].v2, vecs[i].t2, vecs[i].rob);
      alu2rs_bypass_enable = vecs[i].alu_en; alu2rs_bypass_reorder = vecs[i].alu_tag;
      alu2rs_bypass_value  = vecs[i].alu_val;
      lsu2rs_bypass_enable = vecs[i].lsu_en; lsu2rs_bypass_reorder = vecs[i].lsu_tag;
      lsu2rs_bypass_value  = vecs[i].lsu_val;
      push(vecs[i].ins_type, vecs[i].pc, vecs[i].imm, vecs[i].exp_rs1, vecs[i].exp_rs2, vecs[i].rob);
      cycle();
      clear_inputs();
    end
    for (int k = 0; k < 3; k++) cycle();
    check("table_drain", 32'(exp_q.size()), 32'd0);

    // Wakeup from the ALU bus three cycles after allocation.
    set_alloc(INS_ADD, 32'h0000_0500, 32'd0, 1, 32'd0, 4'd7, 0, 32'd1, 0, 4'd3);
    push(INS_ADD, 32'h0000_0500, 32'd0, 32'd10, 32'd1, 4'd3);
    cycle();
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      check("wake_wait", 32'(rs2alu_enable), 32'd0);
      cycle();
    end
    alu2rs_bypass_enable = 1'b1; alu2rs_bypass_reorder = 4'd7; alu2rs_bypass_value = 32'd10;
    cycle();
    clear_inputs();
    check("wake_no_same_edge_issue", 32'(rs2alu_enable), 32'd0);
    cycle();
    check("wake_issue", 32'(rs2alu_enable), 32'd1);
    check("wake_rs1",   rs2alu_rs1,         32'd10);
    cycle();

    // rdy_in low freezes state: pending issue waits, allocation is ignored.
    set_alloc(INS_ORI, 32'h0000_0600, 32'h0F, 0, 32'h30, 0, 0, 32'd0, 0, 4'd1);
    push(INS_ORI, 32'h0000_0600, 32'h0F, 32'h30, 32'd0, 4'd1);
    cycle();
    rdy_in = 1'b0;
    set_alloc(INS_ADDI, 32'h0000_0BAD, 32'd1, 0, 32'd1, 0, 0, 32'd1, 0, 4'd9);
    for (int k = 0; k < 3; k++) begin
      cycle();
      clear_inputs();
      check("frozen_no_issue", 32'(rs2alu_enable), 32'd0);
    end
    rdy_in = 1'b1;
    cycle();
    check("unfrozen_issue", 32'(rs2alu_enable), 32'd1);
    cycle();
    check("frozen_no_ghost", 32'(rs2alu_enable), 32'd0);

    // Fill all 16 entries waiting on tag 9; a 17th request must be ignored.
    for (int i = 0; i < 16; i++) begin
      set_alloc(INS_ADD, 32'h0000_2000 + 32'(4 * i), 32'(i), 1, 32'd0, 4'd9, 0, 32'(i), 0, 4'(i));
      push(INS_ADD, 32'h0000_2000 + 32'(4 * i), 32'(i), 32'h99, 32'(i), 4'(i));
      cycle();
      check("full_fill", 32'(rs2dec_full), (i == 15) ? 32'd1 : 32'd0);
    end
    set_alloc(INS_ADDI, 32'h000D_EAD0, 32'd1, 0, 32'd1, 0, 0, 32'd1, 0, 4'd15);
    cycle();
    clear_inputs();
    check("full_hold", 32'(rs2dec_full), 32'd1);
    alu2rs_bypass_enable = 1'b1; alu2rs_bypass_reorder = 4'd9; alu2rs_bypass_value = 32'h99;
    cycle();
    clear_inputs();
    check("full_wake_no_issue", 32'(rs2alu_enable), 32'd0);
    cycle();
    check("full_first_issue", 32'(rs2alu_enable), 32'd1);
    check("full_drop",        32'(rs2dec_full),   32'd0);
    for (int k = 0; k < 17; k++) cycle();
    check("full_drain", 32'(exp_q.size()), 32'd0);

    // Flush with pending entries, a ready entry about to issue, and a same-edge allocation.
    for (int i = 0; i < 4; i++) begin
      set_alloc(INS_XOR, 32'h0000_3000 + 32'(4 * i), 32'd0, 1, 32'd0, 4'd5, 0, 32'd2, 0, 4'(i));
      cycle();
    end
    set_alloc(INS_ADDI, 32'h0000_3100, 32'd4, 0, 32'd4, 0, 0, 32'd0, 0, 4'd6);
    cycle();
    set_alloc(INS_ADDI, 32'h0000_3200, 32'd4, 0, 32'd4, 0, 0, 32'd0, 0, 4'd7);
    rob_flush = 1'b1;
    cycle();
    rob_flush = 1'b0;
    clear_inputs();
    check("flush_enable", 32'(rs2alu_enable), 32'd0);
    check("flush_full",   32'(rs2dec_full),   32'd0);
    check("flush_pc",     rs2alu_pc,          32'd0);
    alu2rs_bypass_enable = 1'b1; alu2rs_bypass_reorder = 4'd5; alu2rs_bypass_value = 32'h55;
    cycle();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("flush_no_issue", 32'(rs2alu_enable), 32'd0);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
